sms4_word_loader: RTL

Bus-side front end for the SMS4 core. Assembles 32-bit words into 128-bit key and data blocks and sequences the core's key load, start, data load and result capture. Returns each 128-bit result as four 32-bit words on a valid/ready output stream. Sits directly upstream and downstream of the core: it drives `kin`, `kvld`, `din`, `load`, `enc` and `start`, and consumes `dout`, `ready`, `busy` and `kstr`.

---
 rtl/sms4_loader_pkg.sv | 20 ++
 rtl/sms4_word_shift.sv | 68 ++++++
 rtl/sms4_word_loader.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/sms4_loader_pkg.sv
// sms4_loader_pkg
// Shared definitions for the SMS4 word loader: the sequencing FSM states,
// the block geometry and the key-load code driven on core_kvld.
package sms4_loader_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FILL   = 3'd1,
    KISSUE = 3'd2,
    KWAIT  = 3'd3,
    DISSUE = 3'd4,
    CWAIT  = 3'd5,
    DRAIN  = 3'd6
  } state_e;

  localparam int         WORDS_PER_BLOCK = 4;
  localparam logic [1:0] KVLD_LOAD       = 2'b01;
  localparam logic [1:0] KVLD_NONE       = 2'b00;

endpackage

// File: rtl/sms4_word_shift.sv
// sms4_word_shift
// Four-word shift/assemble register. Words shifted in enter at the least
// significant end, so the first word of a group ends up most significant.
// A parallel load replaces the whole block. Every word entering the register
// (shifted or loaded) passes through the optional byte reversal.
//
// Optional feature macro: SMS4_LOADER_BYTESWAP_EN (byte-reverse each word).
//
// Ports:
//   clk, reset  clock and synchronous active-high reset (clears the block)
//   load_i      parallel load of par_i (takes priority over shift_i)
//   par_i       block to load
//   shift_i     shift word_i in at the low end
//   word_i      word to shift in
//   blk_o       top OUT_WORDS words of the register
module sms4_word_shift #(
  parameter int BWIDTH    = 32,
  parameter int WORDS     = 4,
  parameter int OUT_WORDS = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          load_i,
  input  logic [WORDS*BWIDTH-1:0]       par_i,
  input  logic                          shift_i,
  input  logic [BWIDTH-1:0]             word_i,
  output logic [OUT_WORDS*BWIDTH-1:0]   blk_o
);

  localparam int BLK_W = WORDS * BWIDTH;

  logic [BLK_W-1:0] blk_q, blk_d;

  function automatic logic [BWIDTH-1:0] swap_w(input logic [BWIDTH-1:0] w);
`ifdef SMS4_LOADER_BYTESWAP_EN
    logic [BWIDTH-1:0] r;
    r = '0;
    for (int b = 0; b < BWIDTH / 8; b++) begin
      r[8*b +: 8] = w[BWIDTH-8-8*b +: 8];
    end
    return r;
`else
    return w;
`endif
  endfunction

  always_comb begin
    blk_d = blk_q;
    if (load_i) begin
      for (int i = 0; i < WORDS; i++) begin
        blk_d[i*BWIDTH +: BWIDTH] = swap_w(par_i[i*BWIDTH +: BWIDTH]);
      end
    end else if (shift_i) begin
      blk_d = {blk_q[BLK_W-BWIDTH-1:0], swap_w(word_i)};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      blk_q <= '0;
    end else begin
      blk_q <= blk_d;
    end
  end

  assign blk_o = blk_q[BLK_W-1 -: OUT_WORDS*BWIDTH];

endmodule

// File: rtl/sms4_word_loader.sv
// sms4_word_loader
// Bus-side front end for the SMS4 core. Collects four 32-bit words into a
// 128-bit key or data block, loads keys into the core, starts data blocks,
// captures the result and returns it as four words (most significant first)
// on a valid/ready stream. A sticky err flags protocol errors and timeouts.
//
// Optional feature macro: SMS4_LOADER_BYTESWAP_EN (byte-reverse every bus
// word in both directions; handled inside sms4_word_shift).
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   in_data/in_key/in_enc      input word, key-group flag, mode (word 0)
//   in_valid/in_ready          input handshake
//   out_data/out_valid/out_ready result word stream
//   err                        sticky error
//   core_kin/core_kvld         key and key-load strobe to the core
//   core_din/core_load/core_enc/core_start  data block, load, mode, start
//   core_dout/core_ready/core_busy/core_kstr  core result and status
module sms4_word_loader
  import sms4_loader_pkg::*;
#(
  parameter int DWIDTH  = 128,
  parameter int BWIDTH  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [BWIDTH-1:0] in_data,
  input  logic              in_key,
  input  logic              in_enc,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [BWIDTH-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              err,
  output logic [DWIDTH-1:0] core_kin,
  output logic [1:0]        core_kvld,
  output logic [DWIDTH-1:0] core_din,
  output logic              core_load,
  output logic              core_enc,
  output logic              core_start,
  input  logic [DWIDTH-1:0] core_dout,
  input  logic              core_ready,
  input  logic              core_busy,
  input  logic              core_kstr
);

  localparam int            TW      = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT);

  state_e            state_q, state_d;
  logic [1:0]        wcnt_q, wcnt_d;
  logic [1:0]        dcnt_q, dcnt_d;
  logic              grp_key_q, grp_key_d;
  logic              enc_q, enc_d;
  logic              key_ok_q, key_ok_d;
  logic              err_q, err_d;
  logic [TW-1:0]     tmo_q, tmo_d;
  logic [DWIDTH-1:0] key_q, key_d;

  logic [DWIDTH-1:0] in_blk;
  logic              in_shift;
  logic              out_load;
  logic              out_shift;
  logic              tmo_hit;

  // A word whose group type disagrees with the latched one is never stored.
  assign in_shift  = in_valid && ((state_q == IDLE) ||
                     ((state_q == FILL) && (in_key == grp_key_q)));
  assign out_load  = (state_q == CWAIT) && core_ready;
  assign out_shift = (state_q == DRAIN) && out_ready;
  assign tmo_hit   = (tmo_q == TMO_MAX);

  sms4_word_shift #(
    .BWIDTH    (BWIDTH),
    .WORDS     (WORDS_PER_BLOCK),
    .OUT_WORDS (WORDS_PER_BLOCK)
  ) u_in_shift (
    .clk     (clk),
    .reset   (reset),
    .load_i  (1'b0),
    .par_i   ('0),
    .shift_i (in_shift),
    .word_i  (in_data),
    .blk_o   (in_blk)
  );

  sms4_word_shift #(
    .BWIDTH    (BWIDTH),
    .WORDS     (WORDS_PER_BLOCK),
    .OUT_WORDS (1)
  ) u_out_shift (
    .clk     (clk),
    .reset   (reset),
    .load_i  (out_load),
    .par_i   (core_dout),
    .shift_i (out_shift),
    .word_i  ('0),
    .blk_o   (out_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      wcnt_q    <= '0;
      dcnt_q    <= '0;
      grp_key_q <= 1'b0;
      enc_q     <= 1'b0;
      key_ok_q  <= 1'b0;
      err_q     <= 1'b0;
      tmo_q     <= '0;
      key_q     <= '0;
    end else begin
      state_q   <= state_d;
      wcnt_q    <= wcnt_d;
      dcnt_q    <= dcnt_d;
      grp_key_q <= grp_key_d;
      enc_q     <= enc_d;
      key_ok_q  <= key_ok_d;
      err_q     <= err_d;
      tmo_q     <= tmo_d;
      key_q     <= key_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    wcnt_d    = wcnt_q;
    dcnt_d    = dcnt_q;
    grp_key_d = grp_key_q;
    enc_d     = enc_q;
    key_ok_d  = key_ok_q;
    err_d     = err_q;
    key_d     = key_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          grp_key_d = in_key;
          if (!in_key) enc_d = in_enc;
          wcnt_d  = 2'd1;
          state_d = FILL;
        end
      end
      FILL: begin
        if (in_valid) begin
          if (in_key != grp_key_q) begin
            err_d   = 1'b1;
            wcnt_d  = 2'd0;
            state_d = IDLE;
          end else if (wcnt_q == 2'd3) begin
            wcnt_d = 2'd0;
            if (grp_key_q) begin
              // The old key is no longer trusted until the new schedule completes.
              key_ok_d = 1'b0;
              state_d  = KISSUE;
            end else if (key_ok_q) begin
              state_d = DISSUE;
            end else begin
              err_d   = 1'b1;
              state_d = IDLE;
            end
          end else begin
            wcnt_d = wcnt_q + 2'd1;
          end
        end
      end
      KISSUE: begin
        key_d   = in_blk;
        state_d = KWAIT;
      end
      KWAIT: begin
        if (core_kstr) begin
          key_ok_d = 1'b1;
          state_d  = IDLE;
        end else if (tmo_hit) begin
          err_d    = 1'b1;
          key_ok_d = 1'b0;
          state_d  = IDLE;
        end
      end
      DISSUE: begin
        if (!core_busy) state_d = CWAIT;
      end
      CWAIT: begin
        if (core_ready) begin
          dcnt_d  = 2'd0;
          state_d = DRAIN;
        end else if (tmo_hit) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
      DRAIN: begin
        if (out_ready) begin
          dcnt_d = dcnt_q + 2'd1;
          if (dcnt_q == 2'd3) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Timeout counter restarts on every state change and only runs while waiting.
    if (state_d != state_q) begin
      tmo_d = '0;
    end else if ((state_q == KWAIT) || (state_q == CWAIT)) begin
      tmo_d = tmo_q + 1'b1;
    end else begin
      tmo_d = '0;
    end
  end

  always_comb begin
    in_ready   = (state_q == IDLE) || (state_q == FILL);
    out_valid  = (state_q == DRAIN);
    err        = err_q;
    core_kvld  = (state_q == KISSUE) ? KVLD_LOAD : KVLD_NONE;
    core_start = (state_q == DISSUE) && !core_busy;
    core_load  = (state_q == DISSUE) && !core_busy;
    core_enc   = enc_q;
    core_din   = in_blk;
    // During the load cycle the freshly assembled block is presented directly;
    // afterwards the captured copy keeps core_kin stable across data groups.
    core_kin   = (state_q == KISSUE) ? in_blk : key_q;
  end

endmodule
